// File: rtl/unordered_input_arbiter_pkg.sv
// unordered_input_arbiter_pkg: widths and types shared with the order-independent summing tree.
// Rev 1.0
`default_nettype none

package unordered_input_arbiter_pkg;
  localparam int NUM_SOURCES_DEF = 4;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int BATCH_SIZE_DEF  = 8;

  typedef logic [$clog2(NUM_SOURCES_DEF)-1:0] src_id_t;
  typedef logic [$clog2(BATCH_SIZE_DEF):0]    batch_cnt_t;
endpackage

`default_nettype wire

// File: rtl/unordered_input_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching req upward from ptr with wraparound.
// Rev 1.0
`default_nettype none

module rr_arbiter
  import unordered_input_arbiter_pkg::*;
#(
  parameter int N = NUM_SOURCES_DEF,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  always_comb begin
    logic [IW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/unordered_input_arbiter.sv
// unordered_input_arbiter: serialises per-source one-deep holds round-robin into the summing tree port.
// Rev 1.0
`default_nettype none

module unordered_input_arbiter
  import unordered_input_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = NUM_SOURCES_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int BATCH_SIZE  = BATCH_SIZE_DEF,
  localparam int IW = $clog2(NUM_SOURCES),
  localparam int BW = $clog2(BATCH_SIZE) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SOURCES-1:0]            src_valid,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SOURCES-1:0]            src_ready,
  output logic                              valid_out,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic [IW-1:0]                     src_id_out,
  input  logic                              ready_in,
  output logic [BW-1:0]                     batch_count,
  output logic                              batch_done
);

  logic                   armed;
  logic [NUM_SOURCES-1:0] hold_valid;
  logic [DATA_WIDTH-1:0]  hold_data [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] take;
  logic [NUM_SOURCES-1:0] grant;
  logic [IW-1:0]          grant_idx;
  logic [IW-1:0]          ptr;
  logic                   any_grant;
  logic                   out_free;
  logic                   load;
  logic                   xfer;

  // armed keeps src_ready low until the first edge after reset release
  assign src_ready = ~hold_valid & {NUM_SOURCES{armed}};
  assign take      = src_valid & src_ready;
  assign out_free  = ~valid_out | ready_in;
  assign load      = out_free & any_grant;
  assign xfer      = valid_out & ready_in;

  rr_arbiter #(.N(NUM_SOURCES)) u_rr (
    .req       (hold_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (take[i]) hold_data[i] <= src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed      <= 1'b0;
      hold_valid <= '0;
      ptr        <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      src_id_out <= '0;
    end else begin
      armed      <= 1'b1;
      // a slot being granted is never being refilled: take needs it empty
      hold_valid <= (hold_valid & ~({NUM_SOURCES{load}} & grant)) | take;
      if (load) ptr <= (grant_idx == IW'(NUM_SOURCES - 1)) ? '0 : grant_idx + 1'b1;
      if (out_free) begin
        valid_out <= any_grant;
        if (any_grant) begin
          data_out   <= hold_data[grant_idx];
          src_id_out <= grant_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batch_count <= '0;
      batch_done  <= 1'b0;
    end else begin
      batch_done <= 1'b0;
      if (xfer) begin
        if (batch_count == BW'(BATCH_SIZE - 1)) begin
          batch_count <= '0;
          batch_done  <= 1'b1;
        end else begin
          batch_count <= batch_count + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_unordered_input_arbiter.sv
// tb_unordered_input_arbiter: directed scenarios plus randomized traffic against a per-source scoreboard.
// Rev 1.0
`default_nettype none

module tb_unordered_input_arbiter;
  import unordered_input_arbiter_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int B = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] src_valid = '0;
  logic [N*W-1:0] src_data = '0;
  logic [N-1:0] src_ready;
  logic         valid_out;
  logic [W-1:0] data_out;
  src_id_t      src_id_out;
  logic         ready_in = 1'b0;
  batch_cnt_t   batch_count;
  logic         batch_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  unordered_input_arbiter #(.NUM_SOURCES(N), .DATA_WIDTH(W), .BATCH_SIZE(B)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .src_id_out  (src_id_out),
    .ready_in    (ready_in),
    .batch_count (batch_count),
    .batch_done  (batch_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; src_valid = '0; ready_in = 1'b0; src_data = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; src_valid = '1; ready_in = 1'b1;
    repeat (3) step();
    total_cnt++;
    if (src_ready !== 4'b0000) $display("FAIL reset_src_ready: got %b want 0000", src_ready);
    else pass_cnt++;
    total_cnt++;
    if ({valid_out, batch_done, batch_count, src_id_out, data_out} !== '0)
      $display("FAIL reset_outputs: got v=%b done=%b cnt=%0d id=%0d d=%h want all 0",
               valid_out, batch_done, batch_count, src_id_out, data_out);
    else pass_cnt++;
    rst_n = 1'b1; src_valid = '0;
    step();
    total_cnt++;
    if ({src_ready, valid_out} !== 5'b1111_0)
      $display("FAIL reset_release: got ready=%b v=%b want 1111 0", src_ready, valid_out);
    else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    ready_in = 1'b1;
    src_data[2*W +: W] = 32'h0000_0010;
    src_valid = 4'b0100;
    step();
    src_valid = '0;
    total_cnt++;
    if ({src_ready, valid_out} !== 5'b1011_0)
      $display("FAIL single_capture: got ready=%b v=%b want 1011 0", src_ready, valid_out);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({valid_out, data_out, src_id_out} !== {1'b1, 32'h10, src_id_t'(2)})
      $display("FAIL single_out: got v=%b d=%h id=%0d want 1 00000010 2", valid_out, data_out, src_id_out);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({valid_out, batch_count} !== {1'b0, batch_cnt_t'(1)})
      $display("FAIL single_after: got v=%b cnt=%0d want 0 1", valid_out, batch_count);
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < N; i++) src_data[i*W +: W] = 32'(i + 1);
    src_valid = '1;
    step();
    src_valid = '0;
    for (int k = 0; k < N; k++) begin
      step();
      total_cnt++;
      if ({valid_out, data_out, src_id_out} !== {1'b1, 32'(k + 1), src_id_t'(k)})
        $display("FAIL fair_order_%0d: got v=%b d=%h id=%0d want 1 %h %0d",
                 k, valid_out, data_out, src_id_out, 32'(k + 1), k);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if ({valid_out, batch_count} !== {1'b0, batch_cnt_t'(4)})
      $display("FAIL fair_idle: got v=%b cnt=%0d want 0 4", valid_out, batch_count);
    else pass_cnt++;
    // pointer back at 0: source 0 must beat source 3
    src_data[0*W +: W] = 32'h30;
    src_data[3*W +: W] = 32'h33;
    src_valid = 4'b1001;
    step();
    src_valid = '0;
    step();
    total_cnt++;
    if ({data_out, src_id_out} !== {32'h30, src_id_t'(0)})
      $display("FAIL fair_ptr_first: got d=%h id=%0d want 30 0", data_out, src_id_out);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({data_out, src_id_out} !== {32'h33, src_id_t'(3)})
      $display("FAIL fair_ptr_second: got d=%h id=%0d want 33 3", data_out, src_id_out);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [N-1:0] hs;
    bit ok;
    do_reset();
    ready_in = 1'b1;
    src_data[1*W +: W] = 32'hA5;
    src_valid = 4'b0010;
    step();
    src_valid = '0;
    ready_in = 1'b0;
    step();
    exp_q.push_back(32'hA5);
    for (int i = 0; i < N; i++) src_data[i*W +: W] = 32'h100 + 32'(i);
    src_valid = '1;
    for (int c = 0; c < 5; c++) begin
      hs = src_valid & src_ready;
      step();
      for (int i = 0; i < N; i++) if (hs[i]) begin
        exp_q.push_back(32'h100 + 32'(i));
        src_valid[i] = 1'b0;
      end
      total_cnt++;
      if ({valid_out, data_out} !== {1'b1, 32'hA5})
        $display("FAIL bp_stable_%0d: got v=%b d=%h want 1 000000a5", c, valid_out, data_out);
      else pass_cnt++;
    end
    total_cnt++;
    if (src_ready !== 4'b0000) $display("FAIL bp_ready: got %b want 0000", src_ready);
    else pass_cnt++;
    ready_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (valid_out === 1'b1) got_q.push_back(data_out);
      step();
    end
    exp_q.sort();
    got_q.sort();
    ok = (got_q.size() == exp_q.size());
    if (ok) for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) ok = 0;
    total_cnt++;
    if (!ok) $display("FAIL bp_exactly_once: got %0d operands want %0d (or contents differ)",
                      got_q.size(), exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_batch();
    int pend[N][$];
    logic [N-1:0] hs;
    bit xp;
    logic [W-1:0] xd;
    int n = 0, sum = 0, pulses = 0;
    do_reset();
    for (int k = 1; k <= B; k++) pend[(k - 1) % N].push_back(k);
    for (int c = 0; c < 100 && !(n == B && c > 40); c++) begin
      ready_in = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) if (!src_valid[i] && pend[i].size() > 0) begin
        src_data[i*W +: W] = 32'(pend[i][0]);
        src_valid[i] = 1'b1;
      end
      hs = src_valid & src_ready;
      xp = valid_out && ready_in;
      xd = data_out;
      step();
      for (int i = 0; i < N; i++) if (hs[i]) begin
        void'(pend[i].pop_front());
        src_valid[i] = 1'b0;
      end
      if (xp) begin
        n++;
        sum += int'(xd);
      end
      if (batch_done === 1'b1) pulses++;
      total_cnt++;
      if ({batch_done, batch_count} !== {(xp && n % B == 0), batch_cnt_t'(n % B)})
        $display("FAIL batch_cycle_%0d: got done=%b cnt=%0d want %b %0d",
                 c, batch_done, batch_count, (xp && n % B == 0), n % B);
      else pass_cnt++;
    end
    total_cnt++;
    if (n != B || pulses != 1)
      $display("FAIL batch_total: got xfers=%0d pulses=%0d want %0d 1", n, pulses, B);
    else pass_cnt++;
    total_cnt++;
    if (sum != 36) $display("FAIL batch_sum: got %0d want 36", sum);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] sb[N][$];
    int wait_g[N];
    int seq[N];
    logic [N-1:0] hs;
    bit xp, pv, inject;
    logic [W-1:0] pd;
    src_id_t pid, s;
    int n = 0;
    do_reset();
    for (int i = 0; i < N; i++) begin seq[i] = 0; wait_g[i] = 0; end
    for (int c = 0; c < 800; c++) begin
      inject = (c < 500);
      ready_in = inject ? ($urandom_range(0, 3) != 0) : 1'b1;
      for (int i = 0; i < N; i++) if (inject && !src_valid[i] && $urandom_range(0, 1) == 1) begin
        src_data[i*W +: W] = {8'(i), 24'(seq[i])};
        seq[i]++;
        src_valid[i] = 1'b1;
      end
      hs = src_valid & src_ready;
      xp = valid_out && ready_in;
      pv = valid_out;
      pd = data_out;
      pid = src_id_out;
      step();
      if (pv && !xp) begin
        total_cnt++;
        if ({valid_out, data_out, src_id_out} !== {1'b1, pd, pid})
          $display("FAIL rnd_hold_%0d: got v=%b d=%h id=%0d want 1 %h %0d",
                   c, valid_out, data_out, src_id_out, pd, pid);
        else pass_cnt++;
      end else if (valid_out === 1'b1) begin
        s = src_id_out;
        total_cnt++;
        if (sb[s].size() == 0 || data_out !== sb[s][0] || data_out[31:24] !== 8'(s))
          $display("FAIL rnd_order_%0d: got d=%h id=%0d want %h", c, data_out, s,
                   (sb[s].size() > 0) ? sb[s][0] : 32'hx);
        else pass_cnt++;
        if (sb[s].size() > 0) void'(sb[s].pop_front());
        wait_g[s] = 0;
        for (int j = 0; j < N; j++) if (j != int'(s) && sb[j].size() > 0) begin
          wait_g[j]++;
          total_cnt++;
          if (wait_g[j] > N - 1)
            $display("FAIL rnd_starve_%0d: src %0d waited %0d grants want <= %0d", c, j, wait_g[j], N - 1);
          else pass_cnt++;
        end
      end
      for (int i = 0; i < N; i++) if (hs[i]) begin
        sb[i].push_back(src_data[i*W +: W]);
        src_valid[i] = 1'b0;
        wait_g[i] = 0;
      end
      if (xp) n++;
      total_cnt++;
      if ({batch_done, batch_count} !== {(xp && n % B == 0), batch_cnt_t'(n % B)})
        $display("FAIL rnd_batch_%0d: got done=%b cnt=%0d want %b %0d",
                 c, batch_done, batch_count, (xp && n % B == 0), n % B);
      else pass_cnt++;
    end
    for (int i = 0; i < N; i++) begin
      total_cnt++;
      if (sb[i].size() != 0) $display("FAIL rnd_drain_src%0d: got %0d left want 0", i, sb[i].size());
      else pass_cnt++;
    end
    total_cnt++;
    if ({valid_out, src_valid} !== '0)
      $display("FAIL rnd_idle: got v=%b src_valid=%b want 0 0000", valid_out, src_valid);
    else pass_cnt++;
  endtask

  task automatic test_midop_reset();
    do_reset();
    src_data[1*W +: W] = 32'h11;
    src_valid = 4'b0010;
    step();
    src_valid = '0;
    step();
    src_data[0*W +: W] = 32'h20;
    src_data[1*W +: W] = 32'h21;
    src_data[3*W +: W] = 32'h23;
    src_valid = 4'b1011;
    step();
    src_valid = '0;
    total_cnt++;
    if ({valid_out, src_ready} !== 5'b1_0100)
      $display("FAIL mid_setup: got v=%b ready=%b want 1 0100", valid_out, src_ready);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({src_ready, valid_out, data_out, src_id_out, batch_count, batch_done} !== '0)
      $display("FAIL mid_reset: got ready=%b v=%b d=%h id=%0d cnt=%0d done=%b want all 0",
               src_ready, valid_out, data_out, src_id_out, batch_count, batch_done);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    ready_in = 1'b1;
    step();
    total_cnt++;
    if (src_ready !== 4'b1111) $display("FAIL mid_release_ready: got %b want 1111", src_ready);
    else pass_cnt++;
    for (int c = 0; c < 8; c++) begin
      step();
      total_cnt++;
      if (valid_out !== 1'b0) $display("FAIL mid_quiet_%0d: got v=%b want 0", c, valid_out);
      else pass_cnt++;
    end
    src_data[2*W +: W] = 32'h77;
    src_valid = 4'b0100;
    step();
    src_valid = '0;
    step();
    total_cnt++;
    if ({valid_out, data_out, src_id_out} !== {1'b1, 32'h77, src_id_t'(2)})
      $display("FAIL mid_resume: got v=%b d=%h id=%0d want 1 00000077 2", valid_out, data_out, src_id_out);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_batch();
    test_random();
    test_midop_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
